// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes and special register ids.
// Used by the decode/write-back stage (pipe_decode_rf) and its register file.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [3:0] RNONE   = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two read ports, two write ports (E and M).
// M wins when both ports target the same register. Ids of RNONE or >= NREGS
// are never written and read back as zero.
// Optional macro PIPE_DECODE_WB_BYPASS_EN forwards same-cycle write data to
// the read ports (M before E); otherwise reads see the pre-edge contents.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m
);

    logic [DATA_W-1:0] rf_r [NREGS];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // True when an id names an architectural register.
    function automatic logic id_valid(input logic [3:0] id);
        return (id != RNONE) && (32'(id) < NREGS);
    endfunction

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        localparam logic [3:0]        REG_ID   = 4'(g);
        localparam logic [DATA_W-1:0] REG_INIT = (REG_ID == RRSP) ? RSP_INIT : '0;

        // Per-register update: reset init, then M port over E port.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rf_r[g] <= REG_INIT;
            end else if (dst_m == REG_ID && REG_ID != RNONE) begin
                rf_r[g] <= val_m;
            end else if (dst_e == REG_ID && REG_ID != RNONE) begin
                rf_r[g] <= val_e;
            end else begin
                rf_r[g] <= rf_r[g];
            end
        end
    end

    // Array read of both ports; unmatched or invalid ids yield zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (id_valid(src_a) && src_a == 4'(i)) begin
                rd_a_s = rf_r[i];
            end else begin
                rd_a_s = rd_a_s;
            end
            if (id_valid(src_b) && src_b == 4'(i)) begin
                rd_b_s = rf_r[i];
            end else begin
                rd_b_s = rd_b_s;
            end
        end
    end

`ifdef PIPE_DECODE_WB_BYPASS_EN
    // Forward same-cycle write data onto the read ports, M ahead of E.
    always_comb begin
        val_a = rd_a_s;
        val_b = rd_b_s;
        if (id_valid(src_a) && src_a == dst_m) begin
            val_a = val_m;
        end else if (id_valid(src_a) && src_a == dst_e) begin
            val_a = val_e;
        end else begin
            val_a = rd_a_s;
        end
        if (id_valid(src_b) && src_b == dst_m) begin
            val_b = val_m;
        end else if (id_valid(src_b) && src_b == dst_e) begin
            val_b = val_e;
        end else begin
            val_b = rd_b_s;
        end
    end
`else
    // Reads return the pre-edge register contents.
    always_comb begin
        val_a = rd_a_s;
        val_b = rd_b_s;
    end
`endif

endmodule

// File: rtl/pipe_decode_rf.sv
// Pipelined Y86-64 decode/write-back stage: derives source/destination ids,
// reads operands from y86_regfile and loads the D->E pipeline register under
// stall/bubble control. Optional macro PIPE_DECODE_WB_BYPASS_EN enables
// write-back forwarding inside the register file.
module pipe_decode_rf
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [3:0]        d_rA,
    input  logic [3:0]        d_rB,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valP,
    input  logic              d_stall,
    input  logic              d_bubble,
    input  logic [3:0]        w_dstE,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [3:0]        w_dstM,
    input  logic [DATA_W-1:0] w_valM,
    output logic [3:0]        e_icode,
    output logic [3:0]        e_ifun,
    output logic [DATA_W-1:0] e_valC,
    output logic [DATA_W-1:0] e_valA,
    output logic [DATA_W-1:0] e_valB,
    output logic [3:0]        e_srcA,
    output logic [3:0]        e_srcB,
    output logic [3:0]        e_dstE,
    output logic [3:0]        e_dstM
);

    logic [3:0]        src_a_s;
    logic [3:0]        src_b_s;
    logic [3:0]        dst_e_s;
    logic [3:0]        dst_m_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] val_a_s;

    y86_regfile #(
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .src_a (src_a_s),
        .src_b (src_b_s),
        .val_a (rf_a_s),
        .val_b (rf_b_s),
        .dst_e (w_dstE),
        .val_e (w_valE),
        .dst_m (w_dstM),
        .val_m (w_valM)
    );

    // Source/destination id decode from the instruction code.
    always_comb begin
        src_a_s = RNONE;
        src_b_s = RNONE;
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (d_icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a_s = d_rA;
            IRET, IPOPQ:                    src_a_s = RRSP;
            default:                        src_a_s = RNONE;
        endcase
        case (d_icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         src_b_s = d_rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     src_b_s = RRSP;
            default:                        src_b_s = RNONE;
        endcase
        case (d_icode)
            IRRMOVQ, IIRMOVQ, IOPQ:         dst_e_s = d_rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     dst_e_s = RRSP;
            default:                        dst_e_s = RNONE;
        endcase
        case (d_icode)
            IMRMOVQ, IPOPQ:                 dst_m_s = d_rA;
            default:                        dst_m_s = RNONE;
        endcase
    end

    // valA carries the incremented PC for jumps and calls.
    always_comb begin
        val_a_s = rf_a_s;
        if (d_icode == IJXX || d_icode == ICALL) begin
            val_a_s = d_valP;
        end else begin
            val_a_s = rf_a_s;
        end
    end

    // D->E pipeline register: reset > stall (hold) > bubble (NOP) > load.
    always_ff @(posedge clk) begin
        if (!rst_n || (!d_stall && d_bubble)) begin
            e_icode <= INOP;
            e_ifun  <= 4'h0;
            e_valC  <= '0;
            e_valA  <= '0;
            e_valB  <= '0;
            e_srcA  <= RNONE;
            e_srcB  <= RNONE;
            e_dstE  <= RNONE;
            e_dstM  <= RNONE;
        end else if (d_stall) begin
            e_icode <= e_icode;
            e_ifun  <= e_ifun;
            e_valC  <= e_valC;
            e_valA  <= e_valA;
            e_valB  <= e_valB;
            e_srcA  <= e_srcA;
            e_srcB  <= e_srcB;
            e_dstE  <= e_dstE;
            e_dstM  <= e_dstM;
        end else begin
            e_icode <= d_icode;
            e_ifun  <= d_ifun;
            e_valC  <= d_valC;
            e_valA  <= val_a_s;
            e_valB  <= rf_b_s;
            e_srcA  <= src_a_s;
            e_srcB  <= src_b_s;
            e_dstE  <= dst_e_s;
            e_dstM  <= dst_m_s;
        end
    end

endmodule

// File: tb/tb_pipe_decode_rf.sv
// Directed self-checking bench for pipe_decode_rf (RSP_INIT = 64'h100).
// Expected bypass result follows PIPE_DECODE_WB_BYPASS_EN.
module tb_pipe_decode_rf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [63:0] d_valC, d_valP;
    logic        d_stall, d_bubble;
    logic [3:0]  w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [3:0]  e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
    logic [63:0] e_valC, e_valA, e_valB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_decode_rf #(
        .DATA_W   (64),
        .NREGS    (15),
        .RSP_INIT (64'h100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_icode  (d_icode),
        .d_ifun   (d_ifun),
        .d_rA     (d_rA),
        .d_rB     (d_rB),
        .d_valC   (d_valC),
        .d_valP   (d_valP),
        .d_stall  (d_stall),
        .d_bubble (d_bubble),
        .w_dstE   (w_dstE),
        .w_valE   (w_valE),
        .w_dstM   (w_dstM),
        .w_valM   (w_valM),
        .e_icode  (e_icode),
        .e_ifun   (e_ifun),
        .e_valC   (e_valC),
        .e_valA   (e_valA),
        .e_valB   (e_valB),
        .e_srcA   (e_srcA),
        .e_srcB   (e_srcB),
        .e_dstE   (e_dstE),
        .e_dstM   (e_dstM)
    );

    // One rising edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic [3:0] icode, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [63:0] valp);
        d_icode = icode; d_ifun = 4'h0; d_rA = ra; d_rB = rb;
        d_valC = 64'h0; d_valP = valp;
    endtask

    task automatic no_wb();
        w_dstE = 4'hF; w_valE = 64'h0; w_dstM = 4'hF; w_valM = 64'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; d_stall = 1'b0; d_bubble = 1'b0;
        decode(4'h6, 4'h2, 4'h3, 64'h0);
        w_dstE = 4'h2; w_valE = 64'h55; w_dstM = 4'h3; w_valM = 64'h66;
        tick(); tick();
        checks++; if (e_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h exp 1", e_icode); end
        checks++; if ({e_srcA, e_srcB, e_dstE, e_dstM} !== 16'hFFFF) begin errors++; $display("FAIL reset_ids got %h exp ffff", {e_srcA, e_srcB, e_dstE, e_dstM}); end
        checks++; if ({e_valA, e_valB, e_valC} !== 192'h0) begin errors++; $display("FAIL reset_vals got %h/%h/%h exp 0", e_valA, e_valB, e_valC); end
        checks++; if (e_ifun !== 4'h0) begin errors++; $display("FAIL reset_ifun got %h exp 0", e_ifun); end
        rst_n = 1'b1; no_wb();
    endtask

    task automatic test_ret();
        decode(4'h9, 4'hF, 4'hF, 64'h0);
        tick();
        checks++; if (e_icode !== 4'h9) begin errors++; $display("FAIL ret_icode got %h exp 9", e_icode); end
        checks++; if (e_srcA !== 4'h4 || e_srcB !== 4'h4) begin errors++; $display("FAIL ret_src got %h/%h exp 4/4", e_srcA, e_srcB); end
        checks++; if (e_valA !== 64'h100 || e_valB !== 64'h100) begin errors++; $display("FAIL ret_vals got %h/%h exp 100/100", e_valA, e_valB); end
        checks++; if (e_dstE !== 4'h4 || e_dstM !== 4'hF) begin errors++; $display("FAIL ret_dst got %h/%h exp 4/f", e_dstE, e_dstM); end
    endtask

    task automatic test_writeback();
        decode(4'h1, 4'hF, 4'hF, 64'h0);
        w_dstE = 4'h2; w_valE = 64'h5; w_dstM = 4'h3; w_valM = 64'h7;
        tick();
        no_wb();
        decode(4'h6, 4'h2, 4'h3, 64'h0);
        tick();
        checks++; if (e_valA !== 64'h5 || e_valB !== 64'h7) begin errors++; $display("FAIL wb_vals got %h/%h exp 5/7", e_valA, e_valB); end
        checks++; if (e_dstE !== 4'h3 || e_srcA !== 4'h2 || e_srcB !== 4'h3 || e_dstM !== 4'hF) begin errors++; $display("FAIL wb_ids got %h%h%h%h exp 323f", e_srcA, e_srcB, e_dstE, e_dstM); end
    endtask

    task automatic test_m_priority();
        decode(4'h1, 4'hF, 4'hF, 64'h0);
        w_dstE = 4'h4; w_valE = 64'h8; w_dstM = 4'h4; w_valM = 64'h9;
        tick();
        no_wb();
        decode(4'h9, 4'hF, 4'hF, 64'h0);
        tick();
        checks++; if (e_valA !== 64'h9 || e_valB !== 64'h9) begin errors++; $display("FAIL m_priority got %h/%h exp 9/9", e_valA, e_valB); end
    endtask

    task automatic test_call_and_rnone();
        decode(4'h8, 4'h2, 4'h3, 64'h2A);
        tick();
        checks++; if (e_valA !== 64'h2A || e_srcA !== 4'hF) begin errors++; $display("FAIL call_valA got %h src %h exp 2a src f", e_valA, e_srcA); end
        checks++; if (e_srcB !== 4'h4 || e_dstE !== 4'h4 || e_valB !== 64'h9) begin errors++; $display("FAIL call_rsp got %h/%h/%h exp 4/4/9", e_srcB, e_dstE, e_valB); end
        w_dstE = 4'hF; w_valE = 64'hDEAD; w_dstM = 4'hF; w_valM = 64'hBEEF;
        decode(4'h1, 4'hF, 4'hF, 64'h0);
        tick();
        no_wb();
        decode(4'h6, 4'h2, 4'h3, 64'h0);
        tick();
        checks++; if (e_valA !== 64'h5 || e_valB !== 64'h7) begin errors++; $display("FAIL rnone_write got %h/%h exp 5/7", e_valA, e_valB); end
        decode(4'hA, 4'hF, 4'hF, 64'h0);
        tick();
        checks++; if (e_valA !== 64'h0 || e_valB !== 64'h9) begin errors++; $display("FAIL rnone_read got %h/%h exp 0/9", e_valA, e_valB); end
    endtask

    task automatic test_stall_bubble();
        decode(4'h6, 4'h2, 4'h3, 64'h0);
        d_ifun = 4'h1; d_valC = 64'h55;
        tick();
        d_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            decode(4'h3, 4'h4, 4'h4, 64'h99);
            d_valC = 64'hABC0 + 64'(i);
            d_bubble = (i == 2);
            tick();
            checks++; if (e_icode !== 4'h6 || e_ifun !== 4'h1 || e_valC !== 64'h55 || e_valA !== 64'h5 || e_valB !== 64'h7 || e_dstE !== 4'h3)
                begin errors++; $display("FAIL stall_hold cyc %0d got %h %h %h %h %h %h exp 6 1 55 5 7 3", i, e_icode, e_ifun, e_valC, e_valA, e_valB, e_dstE); end
        end
        d_stall = 1'b0; d_bubble = 1'b1;
        tick();
        d_bubble = 1'b0;
        checks++; if (e_icode !== 4'h1 || e_ifun !== 4'h0) begin errors++; $display("FAIL bubble_icode got %h/%h exp 1/0", e_icode, e_ifun); end
        checks++; if ({e_srcA, e_srcB, e_dstE, e_dstM} !== 16'hFFFF || {e_valA, e_valB, e_valC} !== 192'h0)
            begin errors++; $display("FAIL bubble_fields got %h %h %h %h exp ffff 0", {e_srcA, e_srcB, e_dstE, e_dstM}, e_valA, e_valB, e_valC); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_a;
`ifdef PIPE_DECODE_WB_BYPASS_EN
        exp_a = 64'hBEEF;
`else
        exp_a = 64'h1111;
`endif
        decode(4'h1, 4'hF, 4'hF, 64'h0);
        w_dstE = 4'h5; w_valE = 64'h1111;
        tick();
        no_wb();
        decode(4'h6, 4'h5, 4'h2, 64'h0);
        w_dstM = 4'h5; w_valM = 64'hBEEF;
        tick();
        no_wb();
        checks++; if (e_valA !== exp_a || e_valB !== 64'h5) begin errors++; $display("FAIL bypass got %h/%h exp %h/5", e_valA, e_valB, exp_a); end
        tick();
        checks++; if (e_valA !== 64'hBEEF) begin errors++; $display("FAIL after_bypass got %h exp beef", e_valA); end
    endtask

    task automatic test_mid_reset();
        decode(4'h1, 4'hF, 4'hF, 64'h0);
        rst_n = 1'b0;
        w_dstE = 4'h2; w_valE = 64'h77; w_dstM = 4'h4; w_valM = 64'h88;
        tick();
        rst_n = 1'b1; no_wb();
        decode(4'h6, 4'h2, 4'h4, 64'h0);
        tick();
        checks++; if (e_valA !== 64'h0 || e_valB !== 64'h100) begin errors++; $display("FAIL mid_reset got %h/%h exp 0/100", e_valA, e_valB); end
    endtask

    initial begin
        test_reset();
        test_ret();
        test_writeback();
        test_m_priority();
        test_call_and_rnone();
        test_stall_bubble();
        test_bypass();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_decode_rf.md
Name: pipe_decode_rf

Overview:
- Decode/write-back stage for the pipelined Y86-64 processor, succeeding the combinational SEQ decode.
- Holds the register file, which has 2 read ports and 2 write ports (E and M).
- Derives srcA/srcB/dstE/dstM from icode, reads operands, and registers the results into the D→E pipeline register.
- The pipeline register supports stall and bubble control from the hazard unit.

Parameters:
- DATA_W, 64: register and operand width in bits.
- NREGS, 15: number of architectural registers, ids 0..NREGS-1. Id 4'hF is RNONE.
- RSP_INIT, 0: reset value of register 4 (%rsp). All other registers reset to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- d_icode  in  4  instruction code from fetch.
- d_ifun  in  4  function code, passed through.
- d_rA  in  4  register specifier A.
- d_rB  in  4  register specifier B.
- d_valC  in  DATA_W  constant word, passed through.
- d_valP  in  DATA_W  incremented PC.
- d_stall  in  1  hold the E register.
- d_bubble  in  1  inject a NOP into the E register.
- w_dstE  in  4  write-back E destination.
- w_valE  in  DATA_W  write-back E data.
- w_dstM  in  4  write-back M destination.
- w_valM  in  DATA_W  write-back M data.
- e_icode, e_ifun  out  4 each  registered.
- e_valC, e_valA, e_valB  out  DATA_W each  registered.
- e_srcA, e_srcB, e_dstE, e_dstM  out  4 each  registered.

Behaviour:
Source and destination decode (combinational):
- srcA = rA for icode 2, 4, 6, A; 4 (%rsp) for 9, B; otherwise F.
- srcB = rB for 4, 5, 6; 4 for 8, 9, A, B; otherwise F.
- dstE = rB for 2, 3, 6; 4 for 8, 9, A, B; otherwise F.
- dstM = rA for 5, B; otherwise F.

Operand read:
- valA = d_valP for icode 7 or 8; otherwise rf[srcA].
- valB = rf[srcB].
- Reading F, or any id ≥ NREGS, returns 0.

Register write:
- Every rising edge, rf[w_dstE] <= w_valE and rf[w_dstM] <= w_valM.
- A write to F or to an id ≥ NREGS is ignored.
- If w_dstE == w_dstM (not F), M wins.
- Write-back is independent of d_stall and d_bubble.

E register, priority order rst_n=0 > d_stall > d_bubble > load:
- Reset or bubble loads: e_icode=1 (NOP), e_ifun=0, e_valC/valA/valB=0, e_src*/e_dst*=F.
- Stall holds all E outputs, including when d_bubble is also asserted.
- Load captures the decoded values.
- Latency: decoded values appear on e_* 1 cycle after presentation.
- Reset also reinitialises rf (RSP_INIT to register 4, 0 to all others). Asserting reset mid-program discards in-flight writes that cycle.

Width rules:
- Register ids are 4 bits; no arithmetic in this block.
- Operands pass through at DATA_W without extension.

Optional Feature:
- Macro: PIPE_DECODE_WB_BYPASS_EN.
- Defined: a same-cycle write whose id matches srcA (or srcB) forwards its data to valA (or valB) combinationally. M has priority over E. The valP select for icode 7/8 still overrides valA.
- Undefined: reads return the pre-edge register contents; the hazard unit must stall one extra cycle.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - Register constants: RRSP=4, RNONE=F.
- One sub-module, y86_regfile: 2R/2W array with reset init, M-priority write, and the optional bypass.
- pipe_decode_rf wraps y86_regfile with the decode logic and the E register.

Test Plan:
- Reset with RSP_INIT=64'h100, then icode=9 (ret) → after 1 cycle: e_icode=9, e_srcA=4, e_srcB=4, e_valA=64'h100, e_valB=64'h100, e_dstE=4.
- Write-back w_dstE=2/w_valE=5 while w_dstM=3/w_valM=7; next cycle decode icode=6, rA=2, rB=3 → e_valA=5, e_valB=7, e_dstE=3.
- w_dstE=4/valE=8 and w_dstM=4/valM=9 in the same cycle; then read %rsp → 9 (M wins).
- icode=8 with d_valP=64'h2A → e_valA=64'h2A, e_srcA=F. Writes to F leave all registers unchanged.
- Load icode=6, then d_stall=1 with new inputs for 3 cycles → e_* held. d_stall=0, d_bubble=1 → e_icode=1, all e_src/e_dst=F, all e_val=0.
- Bypass: with PIPE_DECODE_WB_BYPASS_EN, w_dstM=5/w_valM=64'hBEEF in the same cycle as decode of icode=6, rA=5 → e_valA=64'hBEEF. Without the macro → e_valA equals the old rf[5].
